// File: rtl/div_lut_loader.sv
// Fills the divider LUT with floor((num<<NB_FRAC)/den) for every {num, den!=0}; NB_Q+1 cycles per entry
// using a restoring shift-subtract divider. Write is held stable (valid/ready) until accepted.
module div_lut_loader #(
  parameter int NB_DATA_IN  = 8,
  parameter int NB_DATA_OUT = 8,
  parameter int NB_FRAC     = 6
) (
  input  logic                          clock,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_wr_valid,
  input  logic                          i_wr_ready,
  output logic [2*(NB_DATA_IN-1)-1:0]   o_wr_addr,
  output logic [NB_DATA_OUT-1:0]        o_wr_data
);
  localparam int NB_MAG = NB_DATA_IN - 1;
  localparam int NB_Q   = NB_MAG + NB_FRAC;
  localparam int NB_CNT = $clog2(NB_Q);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_Q - 1);

  typedef enum logic [1:0] {IDLE, DIV, WRITE, DONE} state_t;

  state_t                  state_q;
  logic [NB_MAG-1:0]       num_q, den_q, rem_q;
  logic [NB_Q-1:0]         dvd_q;
  logic [NB_CNT-1:0]       cnt_q;
  logic                    busy_q, done_q, wr_vld_q;
  logic [2*NB_MAG-1:0]     addr_q;
  logic [NB_DATA_OUT-1:0]  data_q;

  logic [NB_MAG:0]         trial;
  logic                    fits;
  logic [NB_MAG-1:0]       rem_d;
  logic [NB_Q-1:0]         dvd_d;
  logic [NB_DATA_OUT-1:0]  sat_d;
  logic                    den_wrap, last_entry;
  logic [NB_MAG-1:0]       num_nxt, den_nxt;

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    trial = {rem_q, dvd_q[NB_Q-1]};
    fits  = (trial >= {1'b0, den_q});
    rem_d = fits ? NB_MAG'(trial - {1'b0, den_q}) : trial[NB_MAG-1:0];
    dvd_d = {dvd_q[NB_Q-2:0], fits};
  end

  generate
    if (NB_Q > NB_DATA_OUT) begin : g_sat
      assign sat_d = (|dvd_d[NB_Q-1:NB_DATA_OUT]) ? '1 : dvd_d[NB_DATA_OUT-1:0];
    end else begin : g_nosat
      assign sat_d = NB_DATA_OUT'(dvd_d);
    end
  endgenerate

  assign den_wrap   = &den_q;
  assign last_entry = den_wrap && (&num_q);
  assign num_nxt    = den_wrap ? num_q + NB_MAG'(1) : num_q;
  assign den_nxt    = den_wrap ? NB_MAG'(1) : den_q + NB_MAG'(1);

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_vld_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= DIV;
            busy_q  <= 1'b1;
            num_q   <= '0;
            den_q   <= NB_MAG'(1);
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + NB_CNT'(1);
          if (cnt_q == CNT_LAST) begin
            state_q  <= WRITE;
            wr_vld_q <= 1'b1;
            addr_q   <= {num_q, den_q};
            data_q   <= sat_d;
          end
        end
        WRITE: begin
          if (i_wr_ready) begin
            wr_vld_q <= 1'b0;
            if (last_entry) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= DIV;
              num_q   <= num_nxt;
              den_q   <= den_nxt;
              dvd_q   <= {num_nxt, {NB_FRAC{1'b0}}};
              rem_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_wr_valid = wr_vld_q;
  assign o_wr_addr  = addr_q;
  assign o_wr_data  = data_q;

endmodule

// File: tb/tb_div_lut_loader.sv
// Bench: default-size instance (A) for latency, spot entries and reset abort; reduced
// instance (B: 4-bit magnitude, 4 frac bits, 6-bit out) for full-table scoreboard under backpressure.
module tb_div_lut_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a_n, start_a, rdy_a, busy_a, done_a, vld_a;
  logic [13:0] addr_a;
  logic [7:0]  data_a;

  logic        rst_b_n, start_b, rdy_b, busy_b, done_b, vld_b;
  logic [7:0]  addr_b;
  logic [5:0]  data_b;

  div_lut_loader u_dut_a (
    .clock(clock), .i_rst_n(rst_a_n), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
    .o_wr_valid(vld_a), .i_wr_ready(rdy_a), .o_wr_addr(addr_a), .o_wr_data(data_a)
  );

  div_lut_loader #(.NB_DATA_IN(5), .NB_DATA_OUT(6), .NB_FRAC(4)) u_dut_b (
    .clock(clock), .i_rst_n(rst_b_n), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
    .o_wr_valid(vld_b), .i_wr_ready(rdy_b), .o_wr_addr(addr_b), .o_wr_data(data_b)
  );

  typedef struct {int addr; int data;} ent_t;
  ent_t q_a[$];
  ent_t q_b[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int num, input int den, input int frac, input int nbo);
    int q;
    int mx;
    q  = (num << frac) / den;
    mx = (1 << nbo) - 1;
    return (q > mx) ? mx : q;
  endfunction

  task automatic push_a(input int n);
    ent_t e;
    q_a.delete();
    for (int num = 0; num < 128 && q_a.size() < n; num++)
      for (int den = 1; den < 128 && q_a.size() < n; den++) begin
        e.addr = (num << 7) | den;
        e.data = ref_q(num, den, 6, 8);
        q_a.push_back(e);
      end
  endtask

  // Pulses start on A with ready high and checks n writes: contents, spacing, valid drop.
  task automatic run_a(input int n);
    int   idx, prev, nhs;
    bit   hs_prev;
    ent_t e;
    idx = 0; prev = 0; nhs = 0; hs_prev = 0;
    push_a(n);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    chk("a_busy_after_start", busy_a, 1);
    while (nhs < n && idx < n * 14 + 40) begin
      if (hs_prev) chk("a_vld_drop", vld_a, 0);
      hs_prev = 0;
      if (vld_a && rdy_a) begin
        e = q_a.pop_front();
        chk("a_addr", addr_a, e.addr);
        chk("a_data", data_a, e.data);
        chk("a_period", idx + 1 - prev, 14);
        prev = idx + 1;
        case (nhs)
          0:   begin chk("a_first_addr", addr_a, 14'h001); chk("a_first_data", data_a, 8'h00); end
          127: begin chk("a_1_1_addr",   addr_a, 14'h081); chk("a_1_1_data",   data_a, 8'h40); end
          253: begin chk("a_1_127_addr", addr_a, 14'h0FF); chk("a_1_127_data", data_a, 8'h00); end
          382: begin chk("a_3_2_addr",   addr_a, 14'h182); chk("a_3_2_data",   data_a, 8'h60); end
          508: begin chk("a_4_1_addr",   addr_a, 14'h201); chk("a_4_1_sat",    data_a, 8'hFF); end
          default: ;
        endcase
        nhs++;
        hs_prev = 1;
      end
      @(negedge clock);
      idx++;
    end
    chk("a_write_count", nhs, n);
  endtask

  int   idx_b, nhs_b, last_hs_b, prev_addr_b, held_addr_b, held_data_b, wt;
  bit   stall_prev, done_seen, busy_start_sent;
  ent_t eb;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    rdy_a   = 1'b1; rdy_b   = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_vld",  vld_a,  0);
    chk("rst_addr", addr_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_b_vld", vld_b, 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_ready_no_vld", vld_a, 0);
    chk("idle_no_busy",      busy_a, 0);

    run_a(520);

    // Abort in the middle of a stalled write
    rdy_a = 1'b0;
    wt = 0;
    while (!vld_a && wt < 40) begin @(negedge clock); wt++; end
    chk("a_vld_before_rst", vld_a, 1);
    held_addr_b = int'(addr_a);
    held_data_b = int'(data_a);
    repeat (3) @(negedge clock);
    chk("a_stall_vld",  vld_a, 1);
    chk("a_stall_addr", addr_a, held_addr_b);
    chk("a_stall_data", data_a, held_data_b);
    #2 rst_a_n = 1'b0;
    #1;
    chk("a_rst_vld",  vld_a,  0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_addr", addr_a, 0);
    chk("a_rst_data", data_a, 0);
    @(negedge clock);
    rst_a_n = 1'b1;
    rdy_a   = 1'b1;
    repeat (20) @(negedge clock);
    chk("a_no_write_after_abort", vld_a, 0);
    run_a(3);

    // Full reduced table with random backpressure
    q_b.delete();
    for (int num = 0; num < 16; num++)
      for (int den = 1; den < 16; den++) begin
        eb.addr = (num << 4) | den;
        eb.data = ref_q(num, den, 4, 6);
        q_b.push_back(eb);
      end
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    chk("b_busy_after_start", busy_b, 1);
    idx_b = 0; nhs_b = 0; last_hs_b = -1; prev_addr_b = -1;
    stall_prev = 0; done_seen = 0; busy_start_sent = 0;
    while (!done_seen && idx_b < 8000) begin
      start_b = 1'b0;
      if (stall_prev) begin
        chk("b_stall_vld",  vld_b, 1);
        chk("b_stall_addr", addr_b, held_addr_b);
        chk("b_stall_data", data_b, held_data_b);
      end
      if (done_b) begin
        done_seen = 1;
        chk("b_done_timing", idx_b, last_hs_b);
        chk("b_done_busy",   busy_b, 0);
        chk("b_done_count",  nhs_b, 240);
        start_b = 1'b1;
      end else begin
        if (nhs_b == 60 && !busy_start_sent) begin
          start_b = 1'b1;
          busy_start_sent = 1;
        end
        rdy_b = ($urandom_range(0, 2) != 0);
        if (vld_b && rdy_b) begin
          if (q_b.size() == 0) begin
            chk("b_extra_write", 1, 0);
          end else begin
            eb = q_b.pop_front();
            chk("b_addr", addr_b, eb.addr);
            chk("b_data", data_b, eb.data);
          end
          chk("b_ascending", int'(addr_b) > prev_addr_b, 1);
          chk("b_den_nonzero", addr_b[3:0] != 4'd0, 1);
          if (nhs_b == 225) begin chk("b_15_1_addr", addr_b, 8'hF1); chk("b_15_1_sat", data_b, 6'h3F); end
          if (nhs_b == 239) begin chk("b_last_addr", addr_b, 8'hFF); chk("b_last_data", data_b, 6'h10); end
          prev_addr_b = int'(addr_b);
          last_hs_b = idx_b + 1;
          nhs_b++;
        end
        stall_prev = vld_b && !rdy_b;
        held_addr_b = int'(addr_b);
        held_data_b = int'(data_b);
      end
      @(negedge clock);
      idx_b++;
    end
    start_b = 1'b0;
    chk("b_done_seen",   done_seen, 1);
    chk("b_done_single", done_b, 0);
    chk("b_queue_empty", q_b.size(), 0);
    repeat (5) @(negedge clock);
    chk("b_start_in_done_ignored", busy_b, 0);
    chk("b_idle_no_vld", vld_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
